// File: rtl/mips_prog_loader.sv
// Byte-stream program loader for the pipelined MIPS core.
// Assembles framed big-endian words into instruction memory, then releases the core.
module mips_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_halt,
    output logic              cpu_start,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_CSUM, S_START, S_ERROR
    } state_t;

    // Largest word count that still fits between BASE_ADDR and the top of memory.
    localparam logic [63:0]       LIMIT = (64'd1 << ADDR_W) - 64'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    state_t            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              halt_q, halt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic xfer;
    logic hdr;
    logic cnt_ok;
    logic last_byte;
    logic last_word;
    logic csum_ok;

    assign xfer      = in_valid & in_ready;
    assign hdr       = (in_data == 8'hA5);
    assign cnt_ok    = (in_data != 8'd0) && ({56'd0, in_data} <= LIMIT);
    assign last_byte = (bcnt_q == 2'd3);
    assign last_word = ((idx_q + 8'd1) == n_q);
    assign csum_ok   = (in_data == xor_q);

    // State register.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame parser: advance on accepted bytes, START always lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (xfer && hdr) state_d = S_COUNT;
            S_COUNT: if (xfer) state_d = cnt_ok ? S_DATA : S_ERROR;
            S_DATA:  if (xfer && last_byte && last_word) state_d = S_CSUM;
            S_CSUM:  if (xfer) state_d = csum_ok ? S_START : S_ERROR;
            S_START: state_d = S_IDLE;
            S_ERROR: if (xfer && hdr) state_d = S_COUNT;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and start pulse decoded straight from the state.
    always_comb begin
        in_ready  = (state_q != S_START);
        cpu_start = (state_q == S_START);
    end

    // Datapath and status flags next-state.
    always_comb begin
        n_d     = n_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        halt_d  = halt_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE, S_ERROR: begin
                if (xfer && hdr) begin
                    halt_d = 1'b1;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    n_d    = in_data;
                    idx_d  = 8'd0;
                    bcnt_d = 2'd0;
                    xor_d  = 8'd0;
                    if (!cnt_ok) err_d = 1'b1;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    asm_d  = {asm_q[15:0], in_data};
                    xor_d  = xor_q ^ in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (last_byte) begin
                        we_d    = 1'b1;
                        addr_d  = BASE + ADDR_W'(idx_q);
                        wdata_d = {asm_q, in_data};
                        idx_d   = idx_q + 8'd1;
                    end
                end
            end
            S_CSUM: begin
                if (xfer && !csum_ok) err_d = 1'b1;
            end
            S_START: begin
                done_d = 1'b1;
                halt_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            n_q     <= 8'd0;
            idx_q   <= 8'd0;
            bcnt_q  <= 2'd0;
            asm_q   <= 24'd0;
            xor_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= BASE;
            wdata_q <= 32'd0;
            halt_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            n_q     <= n_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            xor_q   <= xor_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            halt_q  <= halt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_halt  = halt_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Byte-stream program loader that sits directly upstream of the pipelined MIPS core. It receives a framed program image and assembles big-endian 32-bit instruction words. It writes them into the core's instruction memory at consecutive addresses. On a valid checksum it releases the core with a one-cycle start pulse; the core has been held halted during loading.

## Interface
- ADDR_W, 10, instruction memory word-address width
- BASE_ADDR, 0, word address of first loaded instruction
- clk1  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte (transfer = in_valid & in_ready)
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  word address for write
- mem_wdata  out  32  instruction word
- cpu_halt  out  1  hold core halted (drives core HALTED)
- cpu_start  out  1  one-cycle pulse: core loads PC=0, HALTED=0, BRANCH_TAKEN=0
- done  out  1  last frame loaded and verified
- err  out  1  last frame rejected

## Operation
- Frame: header 0xA5, count N (words, 8-bit), N×4 data bytes MSB first, checksum = XOR of all 4N data bytes.
- States: IDLE, COUNT, DATA, CSUM, START, ERROR.
- IDLE: bytes other than 0xA5 are consumed and ignored. 0xA5 → COUNT; cpu_halt=1, done=0, err=0 from next cycle.
- COUNT: N=0 or N > 2^ADDR_W − BASE_ADDR → ERROR; else latch N, clear word index, byte counter and running XOR → DATA.
- DATA: shift byte into 32-bit assembly register (new byte enters bits [7:0], prior bytes shift up). XOR it into the running checksum. On the 4th byte of a word, write that word at BASE_ADDR+index. Increment index; index==N → CSUM.
- CSUM: byte == running XOR → START; else → ERROR.
- START (1 cycle): cpu_start=1, cpu_halt=1, in_ready=0 → IDLE with done=1, cpu_halt=0.
- ERROR: err=1, cpu_halt=1. A new 0xA5 → COUNT (err cleared next cycle); other bytes ignored.
- Memory is written before checksum verification; on error, contents are partial/undefined and the core stays halted.
- Address arithmetic is ADDR_W-bit; the range check in COUNT guarantees no wrap.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_halt=1, cpu_start=0, done=0, err=0, state=IDLE.
- in_ready=1 in every state except START; accepts one byte per cycle, back-to-back, no bubbles.
- mem_we is registered: asserted for exactly one cycle, the cycle after the 4th byte of a word is accepted, with mem_addr/mem_wdata valid the same cycle.
- A word accepted on cycle t is written at t+1. A checksum byte accepted on cycle t gives cpu_start=1 at t+1 and done=1, cpu_halt=0 at t+2.
- The last mem_we and the checksum byte acceptance may overlap in the same cycle; both must complete.
- in_valid=0 mid-frame: state held indefinitely, no timeout.
- rst asserted mid-frame: immediate return to reset values, and no further mem_we. Already-written words remain in memory.

## Test plan
- Single word: A5 01 FC 00 00 00 FC → one mem_we, addr 0, data 0xfc000000; cpu_start pulse; done=1, cpu_halt=0.
- Sum program: 10 words 0x0ce77800, 0x2801000f, 0x28020014, 0x28030019, 0x0ce77800, 0x0ce77800, 0x00222000, 0x0ce77800, 0x00832800, 0xfc000000, sent with correct XOR → writes at addr 0..9 in order. Core then halts with R4=35, R5=60.
- Bad checksum: single-word frame with checksum 0x00 → mem_we at addr 0, no cpu_start, err=1, cpu_halt=1. A following valid frame → done=1, err=0.
- Count errors: A5 00 → ERROR. With BASE_ADDR=1020, ADDR_W=10: A5 05 → ERROR, no mem_we.
- Stall and garbage: random in_valid gaps plus leading non-0xA5 bytes in IDLE → identical writes and result to the gap-free run.
- Reset mid-DATA after 6 bytes of a 3-word frame → outputs at reset values immediately; only addr 0 written.
